// File: rtl/axis_pcie_tlp_log_arbiter_if.sv
// Bus bundle for axis_pcie_tlp_log_arbiter: requester push side plus logger output side.
// stat_grants/stat_stalls exist only when AXIS_PCIE_TLP_LOG_ARB_STATS_EN is defined.
interface axis_pcie_tlp_log_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int MSG_W   = 64
);
    localparam int SRC_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ts;
    logic [NUM_REQ*MSG_W-1:0] req_msg;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     log_valid;
    logic                     log_ts_en;
    logic [MSG_W-1:0]         log_msg;
    logic [SRC_W-1:0]         log_src;
    logic                     log_ready;

`ifdef AXIS_PCIE_TLP_LOG_ARB_STATS_EN
    logic [31:0] stat_grants;
    logic [31:0] stat_stalls;

    modport slave (
        input  req_valid, req_ts, req_msg, log_ready,
        output req_ready, log_valid, log_ts_en, log_msg, log_src, stat_grants, stat_stalls
    );
    modport master (
        output req_valid, req_ts, req_msg, log_ready,
        input  req_ready, log_valid, log_ts_en, log_msg, log_src, stat_grants, stat_stalls
    );
`else
    modport slave (
        input  req_valid, req_ts, req_msg, log_ready,
        output req_ready, log_valid, log_ts_en, log_msg, log_src
    );
    modport master (
        output req_valid, req_ts, req_msg, log_ready,
        input  req_ready, log_valid, log_ts_en, log_msg, log_src
    );
`endif
endinterface

// File: rtl/axis_pcie_tlp_log_arbiter.sv
// Round-robin arbiter sharing the TLP logger message port among NUM_REQ FIFO-buffered requesters.
// Optional counters enabled by `define AXIS_PCIE_TLP_LOG_ARB_STATS_EN.
module axis_pcie_tlp_log_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int MSG_W      = 64,
    parameter int FIFO_DEPTH = 4
) (
    input logic                        clk,
    input logic                        SoftReset,
    axis_pcie_tlp_log_arbiter_if.slave bus
);
    localparam int SRC_W = $clog2(NUM_REQ);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PW    = AW + 1;

    typedef enum logic {
        IDLE,
        PRESENT
    } state_t;

    state_t             state;
    logic [MSG_W:0]     mem    [NUM_REQ][FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr [NUM_REQ];
    logic [PW-1:0]      rd_ptr [NUM_REQ];
    logic [NUM_REQ-1:0] full;
    logic [NUM_REQ-1:0] nonempty;
    logic [NUM_REQ-1:0] push;
    logic [NUM_REQ-1:0] pop;
    logic [SRC_W-1:0]   rr_ptr;
    logic [SRC_W-1:0]   cand;
    logic [SRC_W-1:0]   gnt_idx;
    logic [SRC_W-1:0]   rr_next;
    logic               gnt_any;
    logic               load;
    logic [MSG_W:0]     head;

    logic               valid_q;
    logic               ts_q;
    logic [MSG_W-1:0]   msg_q;
    logic [SRC_W-1:0]   src_q;

    // Fullness comes from registered pointers only, so a same-cycle pop never frees a slot.
    always_comb begin
        full     = '0;
        nonempty = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            full[i]     = (wr_ptr[i][PW-1] != rd_ptr[i][PW-1]) &&
                          (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
            nonempty[i] = (wr_ptr[i] != rd_ptr[i]);
        end
    end

    assign bus.req_ready = ~full;
    assign push          = bus.req_valid & ~full;

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = SRC_W'((32'(rr_ptr) + k) % NUM_REQ);
            if (!gnt_any && nonempty[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign rr_next = SRC_W'((32'(gnt_idx) + 32'd1) % NUM_REQ);
    assign load    = gnt_any && ((state == IDLE) || bus.log_ready);
    assign head    = mem[gnt_idx][rd_ptr[gnt_idx][AW-1:0]];

    always_comb begin
        pop = '0;
        if (load) begin
            pop[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i][AW-1:0]] <= {bus.req_ts[i], bus.req_msg[i*MSG_W +: MSG_W]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (SoftReset) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                end
            end
        end
    end

    // A load in PRESENT replaces the consumed record in the same cycle (back-to-back).
    always_ff @(posedge clk) begin
        if (SoftReset) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            ts_q    <= 1'b0;
            msg_q   <= '0;
            src_q   <= '0;
            rr_ptr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        state   <= PRESENT;
                        valid_q <= 1'b1;
                        ts_q    <= head[MSG_W];
                        msg_q   <= head[MSG_W-1:0];
                        src_q   <= gnt_idx;
                        rr_ptr  <= rr_next;
                    end
                end
                PRESENT: begin
                    if (load) begin
                        ts_q   <= head[MSG_W];
                        msg_q  <= head[MSG_W-1:0];
                        src_q  <= gnt_idx;
                        rr_ptr <= rr_next;
                    end else if (bus.log_ready) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.log_valid = valid_q;
    assign bus.log_ts_en = ts_q;
    assign bus.log_msg   = msg_q;
    assign bus.log_src   = src_q;

`ifdef AXIS_PCIE_TLP_LOG_ARB_STATS_EN
    logic [31:0] grants;
    logic [31:0] stalls;

    always_ff @(posedge clk) begin
        if (SoftReset) begin
            grants <= '0;
            stalls <= '0;
        end else begin
            if (valid_q && bus.log_ready && (grants != '1)) begin
                grants <= grants + 32'd1;
            end
            if (valid_q && !bus.log_ready && (stalls != '1)) begin
                stalls <= stalls + 32'd1;
            end
        end
    end

    assign bus.stat_grants = grants;
    assign bus.stat_stalls = stalls;
`endif
endmodule

// File: tb/tb_axis_pcie_tlp_log_arbiter.sv
// Randomised and directed self-checking bench for axis_pcie_tlp_log_arbiter against a queue-based model.
module tb_axis_pcie_tlp_log_arbiter;
    localparam int NR    = 4;
    localparam int MW    = 64;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned checks = 0;
    int unsigned fails  = 0;

    axis_pcie_tlp_log_arbiter_if #(.NUM_REQ(NR), .MSG_W(MW)) bus ();

    axis_pcie_tlp_log_arbiter #(.NUM_REQ(NR), .MSG_W(MW), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .SoftReset(rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Reference: one queue per requester plus the single presented record.
    logic [MW:0]    mq [NR][$];
    logic           m_valid;
    logic           m_ts;
    logic [MW-1:0]  m_msg;
    int unsigned    m_src;
    int unsigned    m_rr;
    longint unsigned m_grants;
    longint unsigned m_stalls;

    task automatic idle_inputs();
        bus.req_valid = '0;
        bus.req_ts    = '0;
        bus.req_msg   = '0;
    endtask

    task automatic tick();
        logic [MW:0]   rec;
        logic [NR-1:0] acc;
        bit            found;
        int unsigned   g;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < NR; i++) mq[i].delete();
            m_valid = 1'b0; m_rr = 0; m_grants = 0; m_stalls = 0;
        end else begin
            for (int i = 0; i < NR; i++) acc[i] = bus.req_valid[i] && (mq[i].size() < DEPTH);
            if (m_valid && bus.log_ready && m_grants != 64'hFFFF_FFFF) m_grants++;
            if (m_valid && !bus.log_ready && m_stalls != 64'hFFFF_FFFF) m_stalls++;
            if (!m_valid || bus.log_ready) begin
                found = 1'b0;
                for (int k = 0; k < NR; k++) begin
                    g = (m_rr + k) % NR;
                    if (!found && mq[g].size() > 0) begin
                        found = 1'b1;
                        rec   = mq[g].pop_front();
                        m_ts  = rec[MW];
                        m_msg = rec[MW-1:0];
                        m_src = g;
                        m_rr  = (g + 1) % NR;
                    end
                end
                m_valid = found;
            end
            for (int i = 0; i < NR; i++)
                if (acc[i]) mq[i].push_back({bus.req_ts[i], bus.req_msg[i*MW +: MW]});
        end
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        bus.log_ready = 1'b0;
        tick();
        tick();
        checks++; if (bus.log_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%0b want=0", bus.log_valid); end
        checks++; if (bus.log_ts_en !== 1'b0) begin fails++; $display("FAIL reset_ts got=%0b want=0", bus.log_ts_en); end
        checks++; if (bus.log_msg !== '0) begin fails++; $display("FAIL reset_msg got=%h want=0", bus.log_msg); end
        checks++; if (bus.log_src !== '0) begin fails++; $display("FAIL reset_src got=%0d want=0", bus.log_src); end
        checks++; if (bus.req_ready !== 4'hF) begin fails++; $display("FAIL reset_ready got=%b want=1111", bus.req_ready); end
`ifdef AXIS_PCIE_TLP_LOG_ARB_STATS_EN
        checks++; if (bus.stat_grants !== 32'd0 || bus.stat_stalls !== 32'd0) begin
            fails++; $display("FAIL reset_stats got=%0d/%0d want=0/0", bus.stat_grants, bus.stat_stalls); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_single();
        bus.log_ready = 1'b1;
        bus.req_valid = 4'b0001;
        bus.req_ts    = 4'b0001;
        bus.req_msg[0 +: MW] = 64'hA5;
        tick();
        idle_inputs();
        checks++; if (bus.log_valid !== 1'b0) begin fails++; $display("FAIL single_t1 valid got=%0b want=0", bus.log_valid); end
        tick();
        checks++; if (bus.log_valid !== 1'b1) begin fails++; $display("FAIL single_t2 valid got=%0b want=1", bus.log_valid); end
        checks++; if (bus.log_msg !== 64'hA5) begin fails++; $display("FAIL single_msg got=%h want=a5", bus.log_msg); end
        checks++; if (bus.log_ts_en !== 1'b1) begin fails++; $display("FAIL single_ts got=%0b want=1", bus.log_ts_en); end
        checks++; if (bus.log_src !== 2'd0) begin fails++; $display("FAIL single_src got=%0d want=0", bus.log_src); end
        tick();
        checks++; if (bus.log_valid !== 1'b0) begin fails++; $display("FAIL single_t3 valid got=%0b want=0", bus.log_valid); end
    endtask

    task automatic test_fairness();
        pulse_reset();
        bus.log_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            bus.req_valid = '1;
            bus.req_ts    = 4'(c * 5);
            for (int i = 0; i < NR; i++) bus.req_msg[i*MW +: MW] = 64'h1000 + 64'(c * 16 + i);
            tick();
        end
        idle_inputs();
        bus.log_ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            checks++; if (bus.log_valid !== 1'b1 || bus.log_src !== 2'(n % NR)) begin
                fails++; $display("FAIL fair_src[%0d] valid=%0b src=%0d want valid=1 src=%0d", n, bus.log_valid, bus.log_src, n % NR); end
            checks++; if (bus.log_msg !== m_msg || bus.log_ts_en !== m_ts) begin
                fails++; $display("FAIL fair_msg[%0d] got=%h/%0b want=%h/%0b", n, bus.log_msg, bus.log_ts_en, m_msg, m_ts); end
            tick();
        end
        checks++; if (bus.log_valid !== 1'b0) begin fails++; $display("FAIL fair_end valid got=%0b want=0", bus.log_valid); end
    endtask

    task automatic test_stall();
        logic [MW-1:0] cap_msg;
        logic [1:0]    cap_src;
        pulse_reset();
        bus.log_ready = 1'b0;
        bus.req_valid = 4'b1000;
        bus.req_msg[3*MW +: MW] = {$urandom(), $urandom()};
        cap_msg = bus.req_msg[3*MW +: MW];
        tick();
        idle_inputs();
        tick();
        cap_src = bus.log_src;
        checks++; if (bus.log_valid !== 1'b1 || bus.log_msg !== cap_msg || cap_src !== 2'd3) begin
            fails++; $display("FAIL stall_load valid=%0b msg=%h src=%0d want 1/%h/3", bus.log_valid, bus.log_msg, cap_src, cap_msg); end
        for (int n = 0; n < 5; n++) begin
            tick();
            checks++; if (bus.log_valid !== 1'b1 || bus.log_msg !== cap_msg || bus.log_src !== cap_src) begin
                fails++; $display("FAIL stall_hold[%0d] valid=%0b msg=%h src=%0d want 1/%h/%0d", n, bus.log_valid, bus.log_msg, bus.log_src, cap_msg, cap_src); end
        end
`ifdef AXIS_PCIE_TLP_LOG_ARB_STATS_EN
        checks++; if (bus.stat_stalls !== 32'd5 || bus.stat_grants !== 32'd0) begin
            fails++; $display("FAIL stall_stats stalls=%0d grants=%0d want 5/0", bus.stat_stalls, bus.stat_grants); end
`endif
        bus.log_ready = 1'b1;
        tick();
        checks++; if (bus.log_valid !== 1'b0) begin fails++; $display("FAIL stall_release valid got=%0b want=0", bus.log_valid); end
`ifdef AXIS_PCIE_TLP_LOG_ARB_STATS_EN
        checks++; if (bus.stat_grants !== 32'd1 || bus.stat_stalls !== 32'd5) begin
            fails++; $display("FAIL stall_grant grants=%0d stalls=%0d want 1/5", bus.stat_grants, bus.stat_stalls); end
`endif
    endtask

    task automatic test_full();
        logic [MW-1:0] exp_msg [6];
        pulse_reset();
        bus.log_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            exp_msg[k]    = 64'h2000 + 64'(k);
            bus.req_valid = 4'b0100;
            bus.req_msg[2*MW +: MW] = exp_msg[k];
            tick();
            checks++; if (bus.req_ready[2] !== (mq[2].size() < DEPTH)) begin
                fails++; $display("FAIL full_ready[%0d] got=%0b want=%0b", k, bus.req_ready[2], mq[2].size() < DEPTH); end
        end
        idle_inputs();
        checks++; if (bus.req_ready[2] !== 1'b0) begin fails++; $display("FAIL full_blocked got=%0b want=0", bus.req_ready[2]); end
        checks++; if (bus.log_msg !== exp_msg[0]) begin fails++; $display("FAIL full_head got=%h want=%h", bus.log_msg, exp_msg[0]); end
        bus.log_ready = 1'b1;
        tick();
        checks++; if (bus.req_ready[2] !== 1'b1) begin fails++; $display("FAIL full_reopen got=%0b want=1", bus.req_ready[2]); end
        for (int n = 1; n < 5; n++) begin
            checks++; if (bus.log_valid !== 1'b1 || bus.log_msg !== exp_msg[n]) begin
                fails++; $display("FAIL full_drain[%0d] valid=%0b msg=%h want 1/%h", n, bus.log_valid, bus.log_msg, exp_msg[n]); end
            tick();
        end
        checks++; if (bus.log_valid !== 1'b0) begin fails++; $display("FAIL full_sixth_dropped valid got=%0b want=0", bus.log_valid); end
    endtask

    task automatic test_reset_mid();
        bus.log_ready = 1'b0;
        bus.req_valid = '1;
        for (int i = 0; i < NR; i++) bus.req_msg[i*MW +: MW] = 64'h3000 + 64'(i);
        tick();
        idle_inputs();
        tick();
        checks++; if (bus.log_valid !== 1'b1) begin fails++; $display("FAIL rstmid_pre valid got=%0b want=1", bus.log_valid); end
        rst = 1'b1;
        tick();
        checks++; if (bus.log_valid !== 1'b0) begin fails++; $display("FAIL rstmid_valid got=%0b want=0", bus.log_valid); end
        checks++; if (bus.req_ready !== 4'hF) begin fails++; $display("FAIL rstmid_ready got=%b want=1111", bus.req_ready); end
        rst = 1'b0;
        bus.req_valid = 4'b1010;
        bus.req_msg[1*MW +: MW] = 64'h3101;
        bus.req_msg[3*MW +: MW] = 64'h3303;
        tick();
        idle_inputs();
        tick();
        checks++; if (bus.log_valid !== 1'b1 || bus.log_src !== 2'd1 || bus.log_msg !== 64'h3101) begin
            fails++; $display("FAIL rstmid_first valid=%0b src=%0d msg=%h want 1/1/3101", bus.log_valid, bus.log_src, bus.log_msg); end
        bus.log_ready = 1'b1;
        tick();
        checks++; if (bus.log_valid !== 1'b1 || bus.log_src !== 2'd3 || bus.log_msg !== 64'h3303) begin
            fails++; $display("FAIL rstmid_second valid=%0b src=%0d msg=%h want 1/3/3303", bus.log_valid, bus.log_src, bus.log_msg); end
        tick();
    endtask

    task automatic test_push_pop();
        logic [MW-1:0] exp_msg [4];
        pulse_reset();
        bus.log_ready = 1'b0;
        for (int k = 0; k < 4; k++) exp_msg[k] = 64'h6000 + 64'(k);
        for (int k = 0; k < 3; k++) begin
            bus.req_valid = 4'b0010;
            bus.req_msg[1*MW +: MW] = exp_msg[k];
            tick();
        end
        checks++; if (bus.log_valid !== 1'b1 || bus.log_msg !== exp_msg[0]) begin
            fails++; $display("FAIL pp_head valid=%0b msg=%h want 1/%h", bus.log_valid, bus.log_msg, exp_msg[0]); end
        bus.log_ready = 1'b1;
        bus.req_msg[1*MW +: MW] = exp_msg[3];
        tick();
        idle_inputs();
        checks++; if (bus.req_ready[1] !== 1'b1 || mq[1].size() != 2) begin
            fails++; $display("FAIL pp_count ready=%0b model_count=%0d want 1/2", bus.req_ready[1], mq[1].size()); end
        for (int n = 1; n < 4; n++) begin
            checks++; if (bus.log_valid !== 1'b1 || bus.log_msg !== exp_msg[n]) begin
                fails++; $display("FAIL pp_order[%0d] valid=%0b msg=%h want 1/%h", n, bus.log_valid, bus.log_msg, exp_msg[n]); end
            tick();
        end
        checks++; if (bus.log_valid !== 1'b0) begin fails++; $display("FAIL pp_end valid got=%0b want=0", bus.log_valid); end
    endtask

    task automatic test_random();
        pulse_reset();
        for (int c = 0; c < 3000; c++) begin
            rst           = ($urandom_range(0, 199) == 0);
            bus.req_valid = 4'($urandom());
            bus.req_ts    = 4'($urandom());
            for (int i = 0; i < NR; i++) bus.req_msg[i*MW +: MW] = {$urandom(), $urandom()};
            bus.log_ready = ($urandom_range(0, 9) < 6);
            tick();
            checks++; if (bus.log_valid !== m_valid) begin
                fails++; $display("FAIL rand_valid[%0d] got=%0b want=%0b", c, bus.log_valid, m_valid); end
            if (m_valid) begin
                checks++; if (bus.log_msg !== m_msg || bus.log_ts_en !== m_ts || bus.log_src !== 2'(m_src)) begin
                    fails++; $display("FAIL rand_rec[%0d] got=%h/%0b/%0d want=%h/%0b/%0d", c, bus.log_msg, bus.log_ts_en, bus.log_src, m_msg, m_ts, m_src); end
            end
            for (int i = 0; i < NR; i++) begin
                checks++; if (bus.req_ready[i] !== (mq[i].size() < DEPTH)) begin
                    fails++; $display("FAIL rand_ready[%0d][%0d] got=%0b want=%0b", c, i, bus.req_ready[i], mq[i].size() < DEPTH); end
            end
`ifdef AXIS_PCIE_TLP_LOG_ARB_STATS_EN
            checks++; if (bus.stat_grants !== 32'(m_grants) || bus.stat_stalls !== 32'(m_stalls)) begin
                fails++; $display("FAIL rand_stats[%0d] got=%0d/%0d want=%0d/%0d", c, bus.stat_grants, bus.stat_stalls, m_grants, m_stalls); end
`endif
        end
        rst = 1'b0;
    endtask

    initial begin
        idle_inputs();
        bus.log_ready = 1'b0;
        m_valid = 1'b0; m_ts = 1'b0; m_msg = '0; m_src = 0; m_rr = 0; m_grants = 0; m_stalls = 0;
        test_reset();
        test_single();
        test_fairness();
        test_stall();
        test_full();
        test_reset_mid();
        test_push_pop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
